// File: rtl/ring_reg_pkg.sv
// ring_reg_pkg: shared constants, the slot header type and the ring distance helper
// used by ring_reg_net and ring_reg_node.
package ring_reg_pkg;

    localparam int RING_MAX_NODES = 16;
    localparam int RING_ID_W      = 4;
    localparam int RING_HDR_W     = 1 + 2 * RING_ID_W;

    typedef struct packed {
        logic                 valid;
        logic [RING_ID_W-1:0] src;
        logic [RING_ID_W-1:0] dest;
    } ring_hdr_t;

    // Hops from s to d going downstream; a self-addressed message travels the full ring.
    function automatic int ring_dist(input int s, input int d, input int n);
        return ((d - s - 1 + n) % n) + 1;
    endfunction

endpackage

// File: rtl/ring_reg_node.sv
// ring_reg_node: one ring stop -- eject/pass/inject mux, eject register and the
// HOP_STAGES-deep outgoing hop; per-node counters exist only with RING_REG_STATS_EN.
module ring_reg_node
    import ring_reg_pkg::*;
#(
    parameter int NUM_NODES  = 2,
    parameter int DATA_W     = 8,
    parameter int HOP_STAGES = 1,
    parameter int NODE_ID    = 0
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [RING_HDR_W-1:0] i_slot_hdr,
    input  logic [DATA_W-1:0]     i_slot_data,
    output logic [RING_HDR_W-1:0] o_slot_hdr,
    output logic [DATA_W-1:0]     o_slot_data,
    input  logic                  i_inj_valid,
    input  logic [RING_ID_W-1:0]  i_inj_dest,
    input  logic [DATA_W-1:0]     i_inj_data,
    output logic                  o_inj_ready,
    output logic                  o_ej_valid,
    output logic [RING_ID_W-1:0]  o_ej_src,
    output logic [DATA_W-1:0]     o_ej_data,
`ifdef RING_REG_STATS_EN
    output logic [15:0]           o_deflect_cnt,
    output logic [15:0]           o_drop_cnt,
`endif
    input  logic                  i_ej_ready
);

    localparam logic [RING_ID_W-1:0] MY_ID     = RING_ID_W'(NODE_ID);
    localparam logic [RING_ID_W:0]   NODES_LIM = (RING_ID_W + 1)'(NUM_NODES);
    localparam int                   PAY_W     = 2 * RING_ID_W + DATA_W;

    ring_hdr_t         in_hdr;
    ring_hdr_t         out_hdr;
    logic [DATA_W-1:0] out_data;
    logic              eject_now;
    logic              inj_fire;
    logic              dest_bad;

    logic                 ej_valid_d, ej_valid_q;
    logic [RING_ID_W-1:0] ej_src_d,   ej_src_q;
    logic [DATA_W-1:0]    ej_data_d,  ej_data_q;

    logic [HOP_STAGES-1:0] hop_vld_d, hop_vld_q;
    logic [PAY_W-1:0]      hop_pay_d [HOP_STAGES];
    logic [PAY_W-1:0]      hop_pay_q [HOP_STAGES];

    assign in_hdr = i_slot_hdr;

    // NOTE: every variable gets a default before the if-chain so no path leaves it unassigned (no latch).
    always_comb begin
        dest_bad    = {1'b0, i_inj_dest} >= NODES_LIM;
        eject_now   = in_hdr.valid && (in_hdr.dest == MY_ID) && (!ej_valid_q || i_ej_ready);
        o_inj_ready = !in_hdr.valid || eject_now;
        inj_fire    = i_inj_valid && o_inj_ready;
        out_hdr     = '0;
        out_data    = i_slot_data;
        if (in_hdr.valid && !eject_now) begin
            out_hdr = in_hdr;
        end else if (inj_fire && !dest_bad) begin
            out_hdr.valid = 1'b1;
            out_hdr.src   = MY_ID;
            out_hdr.dest  = i_inj_dest;
            out_data      = i_inj_data;
        end
    end

    // Accept and refill may coincide, giving one message per cycle.
    always_comb begin
        ej_valid_d = ej_valid_q && !i_ej_ready;
        ej_src_d   = ej_src_q;
        ej_data_d  = ej_data_q;
        if (eject_now) begin
            ej_valid_d = 1'b1;
            ej_src_d   = in_hdr.src;
            ej_data_d  = i_slot_data;
        end
    end

    // NOTE: flops use <= so each one samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            ej_valid_q <= 1'b0;
            ej_src_q   <= '0;
            ej_data_q  <= '0;
        end else begin
            ej_valid_q <= ej_valid_d;
            ej_src_q   <= ej_src_d;
            ej_data_q  <= ej_data_d;
        end
    end

    assign o_ej_valid = ej_valid_q;
    assign o_ej_src   = ej_src_q;
    assign o_ej_data  = ej_data_q;

    always_comb begin
        hop_vld_d[0] = out_hdr.valid;
        hop_pay_d[0] = {out_hdr.src, out_hdr.dest, out_data};
        for (int i = 1; i < HOP_STAGES; i++) begin
            hop_vld_d[i] = hop_vld_q[i-1];
            hop_pay_d[i] = hop_pay_q[i-1];
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            hop_vld_q <= '0;
        end else begin
            hop_vld_q <= hop_vld_d;
        end
    end

    // NOTE: slot payloads carry no reset; their contents only matter while the matching valid is set.
    always_ff @(posedge i_clk) begin
        hop_pay_q <= hop_pay_d;
    end

    assign o_slot_hdr  = {hop_vld_q[HOP_STAGES-1], hop_pay_q[HOP_STAGES-1][PAY_W-1:DATA_W]};
    assign o_slot_data = hop_pay_q[HOP_STAGES-1][DATA_W-1:0];

`ifdef RING_REG_STATS_EN
    logic [15:0] deflect_cnt_d, deflect_cnt_q;
    logic [15:0] drop_cnt_d,    drop_cnt_q;
    logic        deflect_evt;

    always_comb begin
        deflect_evt   = in_hdr.valid && (in_hdr.dest == MY_ID) && !eject_now;
        deflect_cnt_d = deflect_cnt_q;
        drop_cnt_d    = drop_cnt_q;
        if (deflect_evt && (deflect_cnt_q != 16'hFFFF)) begin
            deflect_cnt_d = deflect_cnt_q + 16'd1;
        end
        if (inj_fire && dest_bad && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            deflect_cnt_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            deflect_cnt_q <= deflect_cnt_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    assign o_deflect_cnt = deflect_cnt_q;
    assign o_drop_cnt    = drop_cnt_q;
`endif

endmodule

// File: rtl/ring_reg_net.sv
// ring_reg_net: unidirectional slotted register ring of NUM_NODES ring_reg_node stops.
// Define RING_REG_STATS_EN to add per-node deflection and bad-dest drop counters.
module ring_reg_net
    import ring_reg_pkg::*;
#(
    parameter int NUM_NODES  = 2,
    parameter int DATA_W     = 8,
    parameter int HOP_STAGES = 1
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic [NUM_NODES-1:0]           i_inj_valid,
    input  logic [NUM_NODES*RING_ID_W-1:0] i_inj_dest,
    input  logic [NUM_NODES*DATA_W-1:0]    i_inj_data,
    output logic [NUM_NODES-1:0]           o_inj_ready,
    output logic [NUM_NODES-1:0]           o_ej_valid,
    output logic [NUM_NODES*RING_ID_W-1:0] o_ej_src,
    output logic [NUM_NODES*DATA_W-1:0]    o_ej_data,
`ifdef RING_REG_STATS_EN
    output logic [NUM_NODES*16-1:0]        o_deflect_cnt,
    output logic [NUM_NODES*16-1:0]        o_drop_cnt,
`endif
    input  logic [NUM_NODES-1:0]           i_ej_ready
);

    if (NUM_NODES < 2 || NUM_NODES > RING_MAX_NODES) begin : g_bad_num_nodes
        $error("ring_reg_net: NUM_NODES=%0d outside 2..%0d", NUM_NODES, RING_MAX_NODES);
    end
    if (HOP_STAGES < 1) begin : g_bad_hop_stages
        $error("ring_reg_net: HOP_STAGES=%0d must be at least 1", HOP_STAGES);
    end

    // hop_hdr[n]/hop_data[n] is the last hop stage leaving node n.
    logic [RING_HDR_W-1:0] hop_hdr  [NUM_NODES];
    logic [DATA_W-1:0]     hop_data [NUM_NODES];

    for (genvar n = 0; n < NUM_NODES; n++) begin : g_node
        localparam int PREV = (n + NUM_NODES - 1) % NUM_NODES;

        ring_reg_node #(
            .NUM_NODES  (NUM_NODES),
            .DATA_W     (DATA_W),
            .HOP_STAGES (HOP_STAGES),
            .NODE_ID    (n)
        ) u_node (
            .i_clk         (i_clk),
            .i_rst_n       (i_rst_n),
            .i_slot_hdr    (hop_hdr[PREV]),
            .i_slot_data   (hop_data[PREV]),
            .o_slot_hdr    (hop_hdr[n]),
            .o_slot_data   (hop_data[n]),
            .i_inj_valid   (i_inj_valid[n]),
            .i_inj_dest    (i_inj_dest[n*RING_ID_W +: RING_ID_W]),
            .i_inj_data    (i_inj_data[n*DATA_W +: DATA_W]),
            .o_inj_ready   (o_inj_ready[n]),
            .o_ej_valid    (o_ej_valid[n]),
            .o_ej_src      (o_ej_src[n*RING_ID_W +: RING_ID_W]),
            .o_ej_data     (o_ej_data[n*DATA_W +: DATA_W]),
`ifdef RING_REG_STATS_EN
            .o_deflect_cnt (o_deflect_cnt[n*16 +: 16]),
            .o_drop_cnt    (o_drop_cnt[n*16 +: 16]),
`endif
            .i_ej_ready    (i_ej_ready[n])
        );
    end

endmodule

// File: tb/tb_ring_reg_net.sv
// tb_ring_reg_net: directed bench for ring_reg_net with N=4, DATA_W=8, HOP_STAGES=2;
// counter checks are compiled in when RING_REG_STATS_EN is defined.
`timescale 1ns/1ps
module tb_ring_reg_net;
    import ring_reg_pkg::*;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int HS = 2;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [N-1:0]           inj_valid;
    logic [N*RING_ID_W-1:0] inj_dest;
    logic [N*DW-1:0]        inj_data;
    logic [N-1:0]           inj_ready;
    logic [N-1:0]           ej_valid;
    logic [N*RING_ID_W-1:0] ej_src;
    logic [N*DW-1:0]        ej_data;
    logic [N-1:0]           ej_ready;
`ifdef RING_REG_STATS_EN
    logic [N*16-1:0]        deflect_cnt;
    logic [N*16-1:0]        drop_cnt;
`endif

    int total = 0;
    int bad   = 0;

    int seq    [N];
    int rx_cnt [N];
    bit got    [N][64];

    always #5 clk = ~clk;

    ring_reg_net #(
        .NUM_NODES  (N),
        .DATA_W     (DW),
        .HOP_STAGES (HS)
    ) u_dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_inj_valid   (inj_valid),
        .i_inj_dest    (inj_dest),
        .i_inj_data    (inj_data),
        .o_inj_ready   (inj_ready),
        .o_ej_valid    (ej_valid),
        .o_ej_src      (ej_src),
        .o_ej_data     (ej_data),
`ifdef RING_REG_STATS_EN
        .o_deflect_cnt (deflect_cnt),
        .o_drop_cnt    (drop_cnt),
`endif
        .i_ej_ready    (ej_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [RING_ID_W-1:0] ej_src_of(input int n);
        return ej_src[n*RING_ID_W +: RING_ID_W];
    endfunction

    function automatic logic [DW-1:0] ej_data_of(input int n);
        return ej_data[n*DW +: DW];
    endfunction

    // Presents one injection at a negedge, checks it is accepted, returns one cycle later.
    task automatic send(input int node, input int dest, input logic [DW-1:0] data, input string tag);
        inj_valid[node]                    = 1'b1;
        inj_dest[node*RING_ID_W +: RING_ID_W] = RING_ID_W'(dest);
        inj_data[node*DW +: DW]            = data;
        #1;
        check({tag, "_ready"}, 32'(inj_ready[node]), 32'd1);
        tick();
        inj_valid[node] = 1'b0;
    endtask

    task automatic wait_ej(input int node, input int start, output int lat);
        lat = start;
        while (!ej_valid[node] && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    // Every node n streams to (n+2) mod N; tagged payload {src, seq} lets the bench spot loss or duplicates.
    task automatic run_traffic(input bit rand_ready, input int limit, input string tag);
        logic [DW-1:0] d;
        int s;
        int q;
        for (int n = 0; n < N; n++) begin
            seq[n]    = 0;
            rx_cnt[n] = 0;
            for (int k = 0; k < 64; k++) got[n][k] = 1'b0;
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int n = 0; n < N; n++) begin
                ej_ready[n]  = (rand_ready && cyc < 300) ? 1'($urandom_range(0, 1)) : 1'b1;
                inj_valid[n] = (cyc < 300) && (seq[n] < limit);
                inj_dest[n*RING_ID_W +: RING_ID_W] = RING_ID_W'((n + 2) % N);
                inj_data[n*DW +: DW] = {2'(n), 6'(seq[n])};
            end
            #1;
            for (int n = 0; n < N; n++) begin
                if (inj_valid[n] && inj_ready[n]) seq[n]++;
                if (ej_valid[n] && ej_ready[n]) begin
                    d = ej_data_of(n);
                    s = int'(d[7:6]);
                    q = int'(d[5:0]);
                    check({tag, "_src"}, 32'(ej_src_of(n)), 32'((n + 2) % N));
                    check({tag, "_tag"}, s, 32'((n + 2) % N));
                    check({tag, "_fresh"}, 32'({got[s][q], q < seq[s]}), 32'b01);
                    if (!rand_ready) check({tag, "_order"}, q, rx_cnt[s]);
                    got[s][q] = 1'b1;
                    rx_cnt[s]++;
                end
            end
            @(negedge clk);
        end
        inj_valid = '0;
        for (int n = 0; n < N; n++) begin
            check({tag, "_progress"}, 32'(seq[n] > 0), 32'd1);
            check({tag, "_count"}, rx_cnt[n], seq[n]);
        end
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int         lat;
        logic [N-1:0] seen;

        rst_n     = 1'b0;
        inj_valid = '0;
        inj_dest  = '0;
        inj_data  = '0;
        ej_ready  = '1;

        // Reset: two cycles low, then the first cycle after release.
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("rst_ej_valid",  32'(ej_valid),  32'h0);
        check("rst_inj_ready", 32'(inj_ready), 32'hF);
        check("rst_ej_src",    32'(ej_src),    32'h0);
        check("rst_ej_data",   32'(ej_data),   32'h0);

        // Single message 0 -> 2: k=2, latency 2*2+1 = 5.
        send(0, 2, 8'hA5, "single");
        wait_ej(2, 1, lat);
        check("single_lat",  lat, 5);
        check("single_only", 32'(ej_valid), 32'h4);
        check("single_src",  32'(ej_src_of(2)),  32'd0);
        check("single_data", 32'(ej_data_of(2)), 32'hA5);
        tick();
        check("single_drain", 32'(ej_valid), 32'h0);

        // Self-addressed 3 -> 3: full ring, k=4, latency 9.
        send(3, 3, 8'h3C, "self");
        wait_ej(3, 1, lat);
        check("self_lat",  lat, 9);
        check("self_only", 32'(ej_valid), 32'h8);
        check("self_src",  32'(ej_src_of(3)),  32'd3);
        check("self_data", 32'(ej_data_of(3)), 32'h3C);
        tick();

        // Deflection: fill node 1's eject register while its consumer stalls.
        ej_ready[1] = 1'b0;
        send(0, 1, 8'h77, "defl_fill");
        wait_ej(1, 1, lat);
        check("defl_fill_lat", lat, 3);
        tick();
        tick();
        check("defl_hold_valid", 32'(ej_valid), 32'h2);
        check("defl_hold_data",  32'(ej_data_of(1)), 32'h77);
        send(0, 1, 8'h11, "defl_msg");
        tick();
        check("defl_pass_ready", 32'(inj_ready), 32'hD);
        tick();
        check("defl_held_data", 32'(ej_data_of(1)), 32'h77);
        ej_ready[1] = 1'b1;
        tick();
        check("defl_first_gone", 32'(ej_valid), 32'h0);
        wait_ej(1, 4, lat);
        check("defl_lat",  lat, 11);
        check("defl_src",  32'(ej_src_of(1)),  32'd0);
        check("defl_data", 32'(ej_data_of(1)), 32'h11);
`ifdef RING_REG_STATS_EN
        check("defl_cnt1",    32'(deflect_cnt[31:16]), 32'd1);
        check("defl_cnt_oth", 32'({deflect_cnt[63:32], deflect_cnt[15:0]}), 32'h0);
`endif
        tick();

        // Saturation: first with consumers always ready (ordered), then randomly stalling.
        run_traffic(1'b0, 40, "sat_ord");
        run_traffic(1'b1, 60, "sat_rnd");
        check("sat_idle_ready", 32'(inj_ready), 32'hF);
        check("sat_idle_valid", 32'(ej_valid),  32'h0);

        // Mid-flight reset: one held eject plus three messages on the ring.
        ej_ready[3] = 1'b0;
        send(2, 3, 8'h5A, "mid_hold");
        wait_ej(3, 1, lat);
        check("mid_hold_lat", lat, 3);
        inj_valid = 4'b0111;
        inj_dest  = {4'd0, 4'd0, 4'd3, 4'd2};
        inj_data  = {8'h00, 8'hC2, 8'hC1, 8'hC0};
        #1;
        check("mid_inj_ready", 32'(inj_ready), 32'hF);
        tick();
        inj_valid = '0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid_rst_valid", 32'(ej_valid), 32'h0);
        check("mid_rst_data",  32'(ej_data),  32'h0);
        ej_ready = '1;
        seen = '0;
        repeat (12) begin
            tick();
            seen |= ej_valid;
        end
        check("mid_none", 32'(seen), 32'h0);

        // Bad destinations: dest=7 and the boundary dest=N are accepted and dropped.
        send(0, 7, 8'hEE, "bad7");
        send(1, 4, 8'hEF, "bad4");
        seen = '0;
        repeat (12) begin
            tick();
            seen |= ej_valid;
        end
        check("bad_none", 32'(seen), 32'h0);
`ifdef RING_REG_STATS_EN
        check("bad_drop0",   32'(drop_cnt[15:0]),  32'd1);
        check("bad_drop1",   32'(drop_cnt[31:16]), 32'd1);
        check("bad_drop_hi", 32'(drop_cnt[63:32]), 32'h0);
        check("bad_defl",    32'(deflect_cnt),     32'h0);
`endif
        send(2, 0, 8'h42, "after_bad");
        wait_ej(0, 1, lat);
        check("after_bad_lat",  lat, 5);
        check("after_bad_src",  32'(ej_src_of(0)),  32'd2);
        check("after_bad_data", 32'(ej_data_of(0)), 32'h42);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ring_reg_net.md
Name: ring_reg_net

Overview:
- Parametrised unidirectional slotted ring of NUM_NODES register nodes.
- Successor to the fixed two-node register ring; adds width, node count and hop depth parameters, and per-node client inject/eject ports with valid/ready handshakes and destination addressing.
- Sits between client blocks as a lightweight on-chip message ring. It is also the path-analysis test vehicle for multi-stage register loops through sub-module instances.

Parameters:
- NUM_NODES, 2, number of ring nodes; legal range 2..RING_MAX_NODES (16).
- DATA_W, 8, payload width in bits.
- HOP_STAGES, 1, register stages between node n and node (n+1) mod NUM_NODES; must be ≥1.

Ports:
- i_clk  input  1  sole clock; all logic rising-edge.
- i_rst_n  input  1  synchronous, active-low reset.
- i_inj_valid  input  NUM_NODES  per-node injection request.
- i_inj_dest  input  NUM_NODES*RING_ID_W  per-node destination id.
- i_inj_data  input  NUM_NODES*DATA_W  per-node injection payload.
- o_inj_ready  output  NUM_NODES  per-node injection accept.
- o_ej_valid  output  NUM_NODES  per-node eject data valid.
- o_ej_src  output  NUM_NODES*RING_ID_W  source id of ejected message.
- o_ej_data  output  NUM_NODES*DATA_W  ejected payload.
- i_ej_ready  input  NUM_NODES  per-node eject consumer ready.

Behaviour:
- Reset: the clock is i_clk. Reset is synchronous and active-low on i_rst_n. While i_rst_n=0 at a rising edge, all hop-stage slot valids clear and all o_ej_valid go to 0. o_ej_src and o_ej_data reset to 0. o_inj_ready is combinational, so it reads 1 in the cycle after reset. Reset mid-operation discards all in-flight and held messages; nothing is replayed.
- Slot format: a header of valid, src and dest (ring_hdr_t), plus DATA_W bits of data.
- Ring motion: the ring never stalls. Every hop stage shifts one position per cycle. The input of node n is the output of hop (n-1) mod N.
- Node decision per cycle, in priority order:
  - (a) Input slot valid, dest==n, and the eject register is free or draining (!o_ej_valid || i_ej_ready): eject. The slot is captured into the eject register and the outgoing slot becomes empty.
  - (b) Input slot valid but not ejected: pass through (a deflection, if dest==n).
  - (c) Outgoing slot empty and i_inj_valid[n]: inject {1, n, dest, data}.
- o_inj_ready[n] = !in_valid || eject_now. Ring traffic always has priority over injection. An injection may reuse a slot freed by an ejection in the same cycle.
- Eject handshake: o_ej_valid/src/data hold stable until i_ej_ready. Accept and refill in the same cycle is allowed, which gives one message per cycle throughput.
- Latency: k = ((d - s - 1) mod N) + 1, in the range 1..N. o_ej_valid rises k*HOP_STAGES + 1 cycles after the injection handshake cycle, provided the message is not deflected. A self-addressed message (d==s) circulates the full ring, so k=N.
- Deflected messages circulate again and arrive N*HOP_STAGES cycles later.
- An injection with dest ≥ NUM_NODES is accepted (ready as normal) and dropped; it never enters the ring.
- Parameter-check failures (NUM_NODES out of range, HOP_STAGES<1) raise an elaboration-time $error.

Optional Feature:
- Macro: RING_REG_STATS_EN.
- Defined: adds output o_deflect_cnt (NUM_NODES*16), a per-node saturating count of deflections at that node. It also adds output o_drop_cnt (NUM_NODES*16), a per-node saturating count of bad-dest drops. Both counters reset to 0 and saturate at 16'hFFFF.
- Undefined: neither port exists and there is no counter logic. Ring behaviour is identical either way.

Decomposition:
- Package ring_reg_pkg holds:
  - RING_MAX_NODES=16 and RING_ID_W=4.
  - ring_hdr_t, a packed struct {valid, src, dest}.
  - Function ring_dist(s, d, n), returning k.
- Sub-module ring_reg_node holds:
  - one node's eject/pass/inject mux;
  - its eject register;
  - its HOP_STAGES-deep outgoing pipeline;
  - the optional counters.
- The top level generates NUM_NODES instances and wires them into the ring.

Test Plan:
- N=4, DATA_W=8, HOP_STAGES=2, each case as stimulus -> required response:
- Reset: apply i_rst_n=0 for 2 cycles, then release -> all o_ej_valid=0 and all o_inj_ready=1 in the next cycle.
- Single message: node 0 injects dest=2, data=8'hA5, i_ej_ready all 1 -> o_ej_valid[2] rises exactly 5 cycles after the handshake, with src=0 and data=A5. No other node ejects.
- Self-address: node 3 injects dest=3, data=8'h3C -> o_ej_valid[3] after 9 cycles with src=3.
- Deflection: hold i_ej_ready[1]=0 with the eject register full, then node 0 sends dest=1, data=8'h11. Raise i_ej_ready[1] -> the message ejects 8 cycles after its first arrival. With RING_REG_STATS_EN defined, o_deflect_cnt[1]=1.
- Saturation: all nodes inject continuously to (n+2) mod 4 with random i_ej_ready -> no loss, no duplication, and per-source ordering is preserved when there are no deflections. o_inj_ready[n]=0 whenever the input slot passes through node n.
- Mid-flight reset and bad dest:
  - Reset with 3 messages in flight -> no o_ej_valid afterwards.
  - An injection with dest=7 -> accepted, never ejected; o_drop_cnt increments when the stats feature is enabled.
